// File: rtl/muldiv_pkg.sv
// Shared types and decode constants for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  // Control FSM states of the multiply/divide sequencer.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Funct3 encodings of the M extension.
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  // Fields that identify an M-extension instruction in the EX stage.
  localparam logic [6:0] MEXT_FUNCT7 = 7'b0000001;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

endpackage

// File: rtl/muldiv_iter.sv
// Iteration datapath: radix-2 shift-add multiply and restoring divide on
// unsigned magnitudes, one step per enabled cycle. The {hi, lo} pair holds the
// running product (multiply) or the remainder and quotient/dividend (divide).
module muldiv_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            i_load,
  input  logic            i_en,
  input  logic            i_div,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_last,
  output logic [XLEN-1:0] o_hi,
  output logic [XLEN-1:0] o_lo
);

  localparam int CNT_W = $clog2(XLEN);

  logic [XLEN-1:0]  r_hi;
  logic [XLEN-1:0]  r_lo;
  logic [XLEN-1:0]  r_b;
  logic [CNT_W-1:0] r_cnt;

  logic [XLEN:0]    w_sum;
  logic [XLEN:0]    w_shift;
  logic [XLEN-1:0]  w_diff;
  logic             w_fits;

  // Next-step arithmetic for both algorithms.
  // NOTE: every always_comb output gets a value on every path so no latch is inferred.
  always_comb begin
    w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    w_shift = {r_hi, r_lo[XLEN-1]};
    w_fits  = (w_shift >= {1'b0, r_b});
    // The true difference is below the divisor when it is used, so XLEN bits suffice.
    w_diff  = w_shift[XLEN-1:0] - r_b;
  end

  // Operand load and one shift-add / shift-subtract step per enabled cycle.
  // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_hi  <= '0;
      r_lo  <= '0;
      r_b   <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_hi  <= '0;
      r_lo  <= i_a;
      r_b   <= i_b;
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
      if (i_div) begin
        if (w_fits) begin
          r_hi <= w_diff;
          r_lo <= {r_lo[XLEN-2:0], 1'b1};
        end else begin
          r_hi <= w_shift[XLEN-1:0];
          r_lo <= {r_lo[XLEN-2:0], 1'b0};
        end
      end else begin
        r_hi <= w_sum[XLEN:1];
        r_lo <= {w_sum[0], r_lo[XLEN-1:1]};
      end
    end
  end

  assign o_last = (r_cnt == CNT_W'(XLEN - 1));
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

endmodule

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit beside the EX-stage ALU: decodes M instructions,
// stalls the pipeline while iterating, and returns a registered result with a
// one-cycle done pulse. Divide-by-zero and signed overflow bypass iteration.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [1:0]      ALUOp,
  input  logic [6:0]      Funct7,
  input  logic [2:0]      Funct3,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  input  logic            flush,
  output logic            md_sel,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] Result
);

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t          r_state;
  logic [2:0]      r_f3;
  logic            r_q_neg;
  logic            r_r_neg;
  logic            r_busy;
  logic            r_done;
  logic [XLEN-1:0] r_result;

  logic            w_accept;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_a_mag;
  logic [XLEN-1:0] w_b_mag;
  logic            w_is_div;
  logic            w_div0;
  logic            w_ovf;
  logic            w_special;
  logic [XLEN-1:0] w_special_res;
  logic            w_last;
  logic [XLEN-1:0] w_hi;
  logic [XLEN-1:0] w_lo;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0] w_quot;
  logic [XLEN-1:0] w_rem;
  logic [XLEN-1:0] w_fix_res;

  assign md_sel   = (ALUOp == ALUOP_RTYPE) && (Funct7 == MEXT_FUNCT7);
  assign stall    = start && md_sel && !r_done;
  assign w_accept = (r_state == ST_IDLE) && start && md_sel && !flush;
  assign w_is_div = Funct3[2];

  // Operand sign handling and special-case decode for the request in IDLE.
  always_comb begin
    w_a_neg = SrcA[XLEN-1] &&
              (Funct3 == F3_MULH || Funct3 == F3_MULHSU || Funct3 == F3_DIV || Funct3 == F3_REM);
    w_b_neg = SrcB[XLEN-1] &&
              (Funct3 == F3_MULH || Funct3 == F3_DIV || Funct3 == F3_REM);
    w_a_mag = w_a_neg ? -SrcA : SrcA;
    w_b_mag = w_b_neg ? -SrcB : SrcB;
    w_div0  = (SrcB == '0);
    w_ovf   = (Funct3 == F3_DIV || Funct3 == F3_REM) && (SrcA == MOST_NEG) && (&SrcB);
    w_special = w_is_div && (w_div0 || w_ovf);
    if (w_div0) begin
      w_special_res = Funct3[1] ? SrcA : '1;
    end else begin
      w_special_res = Funct3[1] ? '0 : MOST_NEG;
    end
  end

  muldiv_iter #(
    .XLEN (XLEN)
  ) u_iter (
    .clk     (clk),
    .reset_n (reset_n),
    .i_load  (w_accept && !w_special),
    .i_en    ((r_state == ST_CALC) && !flush),
    .i_div   (r_f3[2]),
    .i_a     (w_a_mag),
    .i_b     (w_b_mag),
    .o_last  (w_last),
    .o_hi    (w_hi),
    .o_lo    (w_lo)
  );

  // Sign correction and result selection applied in FIX.
  always_comb begin
    w_prod = {w_hi, w_lo};
    if (r_q_neg) w_prod = -w_prod;
    w_quot = r_q_neg ? -w_lo : w_lo;
    w_rem  = r_r_neg ? -w_hi : w_hi;
    case (r_f3)
      F3_MUL:           w_fix_res = w_prod[XLEN-1:0];
      F3_DIV, F3_DIVU:  w_fix_res = w_quot;
      F3_REM, F3_REMU:  w_fix_res = w_rem;
      default:          w_fix_res = w_prod[2*XLEN-1:XLEN];
    endcase
  end

  // Sequencer FSM with registered busy, done and Result.
  // NOTE: reset clears only control and the result; there is no memory array to initialise.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_f3     <= F3_MUL;
      r_q_neg  <= 1'b0;
      r_r_neg  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else if (flush) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (w_accept) begin
            r_f3    <= Funct3;
            r_q_neg <= w_a_neg ^ w_b_neg;
            r_r_neg <= w_a_neg;
            if (w_special) begin
              r_result <= w_special_res;
              r_state  <= ST_DONE;
              r_done   <= 1'b1;
            end else begin
              r_state <= ST_CALC;
              r_busy  <= 1'b1;
            end
          end
        end
        ST_CALC: begin
          if (w_last) r_state <= ST_FIX;
        end
        ST_FIX: begin
          r_result <= w_fix_res;
          r_state  <= ST_DONE;
          r_busy   <= 1'b0;
          r_done   <= 1'b1;
        end
        default: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign Result = r_result;

endmodule
